// File: rtl/mem_data_formatter.sv
// Memory-stage data formatter: sizes store data, truncates and extends load data,
// and registers the selected write-back value.
module mem_data_formatter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Dsize,
    input  logic        loadext,
    input  logic        MemtoReg,
    input  logic        valid_in,
    input  logic [31:0] rData,
    input  logic [31:0] BusB,
    input  logic [31:0] ExecResult,
    output logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] wb_data,
    output logic        wb_valid
);

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_RSVD = 2'b10,
        SIZE_WORD = 2'b11
    } accessSize_t;

    function automatic logic [31:0] extender(input logic [15:0] val, input logic ext);
        return {{16{ext & val[15]}}, val};
    endfunction

    function automatic logic [31:0] extender_8(input logic [7:0] val, input logic ext);
        return {{24{ext & val[7]}}, val};
    endfunction

    function automatic logic [31:0] mux_2to1_32(input logic [31:0] a, input logic [31:0] b,
                                                input logic sel);
        return sel ? b : a;
    endfunction

    accessSize_t accessSize;
    logic [31:0] wbNext;

    assign accessSize = accessSize_t'(Dsize);

    always_comb begin
        load_data = 32'h0000_0000;
        unique case (accessSize)
            SIZE_BYTE: load_data = extender_8(rData[7:0], loadext);
            SIZE_HALF: load_data = extender(rData[15:0], loadext);
            SIZE_RSVD: load_data = 32'h0000_0000;
            SIZE_WORD: load_data = rData;
            default:   load_data = 32'h0000_0000;
        endcase
    end

    // Stores are never sign-extended, so the extension control is tied low.
    always_comb begin
        store_data = 32'h0000_0000;
        unique case (accessSize)
            SIZE_BYTE: store_data = extender_8(BusB[7:0], 1'b0);
            SIZE_HALF: store_data = extender(BusB[15:0], 1'b0);
            SIZE_RSVD: store_data = 32'h0000_0000;
            SIZE_WORD: store_data = BusB;
            default:   store_data = 32'h0000_0000;
        endcase
    end

    assign wbNext = mux_2to1_32(ExecResult, load_data, MemtoReg);

    // Captures every cycle regardless of valid_in; consumers qualify with wb_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data  <= 32'h0000_0000;
            wb_valid <= 1'b0;
        end else begin
            wb_data  <= wbNext;
            wb_valid <= valid_in;
        end
    end

endmodule

// File: tb/tb_mem_data_formatter.sv
// Self-checking bench for mem_data_formatter: directed vectors, with write-back
// results checked by a queue-based scoreboard monitor.
module tb_mem_data_formatter;

    logic        clk;
    logic        reset;
    logic [1:0]  Dsize;
    logic        loadext;
    logic        MemtoReg;
    logic        valid_in;
    logic [31:0] rData;
    logic [31:0] BusB;
    logic [31:0] ExecResult;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic [31:0] wb_data;
    logic        wb_valid;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic [31:0] data;
        logic        valid;
    } wbExp_t;

    wbExp_t expQ[$];

    typedef struct {
        logic [1:0]  size;
        logic        ext;
        logic        m2r;
        logic        vld;
        logic [31:0] rd;
        logic [31:0] bb;
        logic [31:0] ex;
        logic [31:0] expLoad;
        logic [31:0] expStore;
    } vec_t;

    mem_data_formatter dut (
        .clk        (clk),
        .reset      (reset),
        .Dsize      (Dsize),
        .loadext    (loadext),
        .MemtoReg   (MemtoReg),
        .valid_in   (valid_in),
        .rData      (rData),
        .BusB       (BusB),
        .ExecResult (ExecResult),
        .store_data (store_data),
        .load_data  (load_data),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    // Drive one vector mid-cycle, check the combinational outputs, and queue the
    // write-back the next rising edge should capture.
    task automatic applyStimulus(input vec_t v, input string name);
        wbExp_t e;
        @(negedge clk);
        Dsize      = v.size;
        loadext    = v.ext;
        MemtoReg   = v.m2r;
        valid_in   = v.vld;
        rData      = v.rd;
        BusB       = v.bb;
        ExecResult = v.ex;
        #1;
        checkOutput({name, " load_data"},  load_data,  v.expLoad);
        checkOutput({name, " store_data"}, store_data, v.expStore);
        e.data  = v.m2r ? v.expLoad : v.ex;
        e.valid = v.vld;
        expQ.push_back(e);
    endtask

    always @(posedge clk) begin
        if (!reset && expQ.size() > 0) begin
            wbExp_t e;
            #1;
            e = expQ.pop_front();
            checkOutput("wb_data",  wb_data,          e.data);
            checkOutput("wb_valid", {31'b0, wb_valid}, {31'b0, e.valid});
        end
    end

    vec_t dirVecs[10] = '{
        '{2'b00, 1'b1, 1'b1, 1'b1, 32'h1234_5680, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FF80, 32'h0000_00EF},
        '{2'b00, 1'b0, 1'b1, 1'b1, 32'h1234_5680, 32'hDEAD_BEEF, 32'h0, 32'h0000_0080, 32'h0000_00EF},
        '{2'b01, 1'b1, 1'b1, 1'b1, 32'hABCD_8001, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_8001, 32'h0000_BEEF},
        '{2'b01, 1'b0, 1'b1, 1'b1, 32'hABCD_8001, 32'hDEAD_BEEF, 32'h0, 32'h0000_8001, 32'h0000_BEEF},
        '{2'b11, 1'b1, 1'b1, 1'b1, 32'hABCD_8001, 32'hDEAD_BEEF, 32'h0, 32'hABCD_8001, 32'hDEAD_BEEF},
        '{2'b11, 1'b0, 1'b1, 1'b1, 32'hABCD_8001, 32'hDEAD_BEEF, 32'h0, 32'hABCD_8001, 32'hDEAD_BEEF},
        '{2'b10, 1'b1, 1'b1, 1'b1, 32'hABCD_8001, 32'hDEAD_BEEF, 32'h0, 32'h0000_0000, 32'h0000_0000},
        '{2'b10, 1'b0, 1'b1, 1'b1, 32'hABCD_8001, 32'hDEAD_BEEF, 32'h0, 32'h0000_0000, 32'h0000_0000},
        '{2'b11, 1'b0, 1'b0, 1'b1, 32'h7777_7777, 32'hDEAD_BEEF, 32'h0000_1000, 32'h7777_7777, 32'hDEAD_BEEF},
        '{2'b11, 1'b0, 1'b1, 1'b1, 32'h7777_7777, 32'hDEAD_BEEF, 32'h0000_1000, 32'h7777_7777, 32'hDEAD_BEEF}
    };

    vec_t streamVecs[8] = '{
        '{2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_00FF, 32'h1122_3344, 32'hAAAA_0000, 32'hFFFF_FFFF, 32'h0000_0044},
        '{2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_F00F, 32'h5566_7788, 32'hAAAA_0000, 32'h0000_F00F, 32'h0000_7788},
        '{2'b11, 1'b1, 1'b0, 1'b1, 32'h89AB_CDEF, 32'h0BAD_F00D, 32'h1234_5678, 32'h89AB_CDEF, 32'h0BAD_F00D},
        '{2'b10, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000},
        '{2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_007F, 32'h0000_01FF, 32'hCAFE_BABE, 32'h0000_007F, 32'h0000_00FF},
        '{2'b01, 1'b1, 1'b1, 1'b0, 32'h1234_7FFF, 32'h0001_8000, 32'h0000_0000, 32'h0000_7FFF, 32'h0000_8000},
        '{2'b00, 1'b1, 1'b1, 1'b1, 32'h8765_43A5, 32'h8765_43A5, 32'h0000_0000, 32'hFFFF_FFA5, 32'h0000_00A5},
        '{2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_C000, 32'h0000_0000, 32'h0000_0042, 32'hFFFF_C000, 32'h0000_0000}
    };

    vec_t preReset  = '{2'b11, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF,
                        32'h0000_0000, 32'h0000_0000};
    vec_t postReset = '{2'b01, 1'b1, 1'b1, 1'b0, 32'h0000_9ABC, 32'h1357_2468, 32'h0000_5555,
                        32'hFFFF_9ABC, 32'h0000_2468};

    initial begin
        reset      = 1'b1;
        Dsize      = 2'b11;
        loadext    = 1'b0;
        MemtoReg   = 1'b1;
        valid_in   = 1'b1;
        rData      = 32'h1111_1111;
        BusB       = 32'h0;
        ExecResult = 32'h0;
        #1;
        checkOutput("reset wb_data",  wb_data,           32'h0);
        checkOutput("reset wb_valid", {31'b0, wb_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hold wb_data",  wb_data,           32'h0);
        checkOutput("reset hold wb_valid", {31'b0, wb_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (dirVecs[i]) applyStimulus(dirVecs[i], $sformatf("dir%0d", i));

        // Load DEAD_BEEF, then pulse reset inside the low phase with the next vector already driven.
        applyStimulus(preReset, "preReset");
        applyStimulus(postReset, "postReset");
        reset = 1'b1;
        #1;
        checkOutput("async wb_data",  wb_data,           32'h0);
        checkOutput("async wb_valid", {31'b0, wb_valid}, 32'h0);
        checkOutput("async load_data", load_data,        32'hFFFF_9ABC);
        #1;
        reset = 1'b0;

        foreach (streamVecs[i]) applyStimulus(streamVecs[i], $sformatf("stream%0d", i));

        for (int n = 0; n < 5 && expQ.size() > 0; n++) @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
